// File: rtl/standoff_pkg.sv
// Shared encodings and state type for the standoff game controller and rule logic.
package standoff_pkg;

  localparam logic [2:0] MOVE_SHOOT  = 3'b100;
  localparam logic [2:0] MOVE_RELOAD = 3'b010;
  localparam logic [2:0] MOVE_BLOCK  = 3'b001;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_COMP = 2'b10;

  localparam logic [1:0] MAX_BULLETS = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_P1,
    ST_SAMPLE,
    ST_RESOLVE,
    ST_HOLD,
    ST_GAME_OVER
  } state_t;

  // A move is playable only if one-hot and the bullet count allows it.
  function automatic logic move_legal(input logic [2:0] mv, input logic [1:0] cnt);
    return (mv == MOVE_BLOCK) ||
           ((mv == MOVE_SHOOT) && (cnt != 2'd0)) ||
           ((mv == MOVE_RELOAD) && (cnt != MAX_BULLETS));
  endfunction

endpackage

// File: rtl/standoff_rules.sv
// Combinational rule evaluation for one round: next bullet counts and winner.
// Both moves are assumed already legalised.
module standoff_rules
  import standoff_pkg::*;
(
  input  logic [2:0] p1_move,
  input  logic [2:0] comp_move,
  input  logic [1:0] p1_cnt,
  input  logic [1:0] comp_cnt,
  output logic [1:0] p1_next,
  output logic [1:0] comp_next,
  output logic [1:0] win
);

  function automatic logic [1:0] sat_inc(input logic [1:0] v);
    return (v == MAX_BULLETS) ? v : v + 2'd1;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] v);
    return (v == 2'd0) ? v : v - 2'd1;
  endfunction

  always_comb begin
    p1_next   = p1_cnt;
    comp_next = comp_cnt;
    win       = WIN_NONE;

    // A reload that gets shot at does not complete.
    if (p1_move == MOVE_SHOOT)
      p1_next = sat_dec(p1_cnt);
    else if ((p1_move == MOVE_RELOAD) && (comp_move != MOVE_SHOOT))
      p1_next = sat_inc(p1_cnt);

    if (comp_move == MOVE_SHOOT)
      comp_next = sat_dec(comp_cnt);
    else if ((comp_move == MOVE_RELOAD) && (p1_move != MOVE_SHOOT))
      comp_next = sat_inc(comp_cnt);

    if ((p1_move == MOVE_SHOOT) && (comp_move == MOVE_RELOAD))
      win = WIN_P1;
    else if ((comp_move == MOVE_SHOOT) && (p1_move == MOVE_RELOAD))
      win = WIN_COMP;
  end

endmodule

// File: rtl/standoff_referee.sv
// Round controller for the standoff game: accepts/legalises moves, resolves rounds,
// holds the reveal, and tracks bullets, winner and round count.
//   state        | meaning
//   ST_IDLE      | after reset, waiting for new_game
//   ST_WAIT_P1   | waiting for a legal player move
//   ST_SAMPLE    | capture and legalise the computer move
//   ST_RESOLVE   | apply rules, publish results
//   ST_HOLD      | reveal held for HOLD_CYCLES cycles
//   ST_GAME_OVER | winner declared, frozen until new_game
module standoff_referee
  import standoff_pkg::*;
#(
  parameter int HOLD_CYCLES   = 50_000_000,
  parameter int START_BULLETS = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       new_game,
  input  logic       p1_valid,
  input  logic [2:0] p1_choice,
  input  logic [2:0] comp_choice,
  output logic [1:0] p1_bullet,
  output logic [1:0] comp_bullet,
  output logic [2:0] p1_shown,
  output logic [2:0] comp_shown,
  output logic [1:0] winner,
  output logic       game_over,
  output logic       round_done,
  output logic       move_reject,
  output logic [7:0] round_count
);

  localparam int             HW        = $clog2(HOLD_CYCLES);
  localparam logic [HW-1:0]  HOLD_LOAD = HW'(HOLD_CYCLES - 1);
  localparam logic [1:0]     START_CNT = 2'(START_BULLETS);

  state_t        state;
  logic [2:0]    p1_move;
  logic [2:0]    comp_move;
  logic [HW-1:0] hold_cnt;
  logic [1:0]    p1_next;
  logic [1:0]    comp_next;
  logic [1:0]    win_next;

  standoff_rules u_rules (
    .p1_move   (p1_move),
    .comp_move (comp_move),
    .p1_cnt    (p1_bullet),
    .comp_cnt  (comp_bullet),
    .p1_next   (p1_next),
    .comp_next (comp_next),
    .win       (win_next)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      p1_move     <= '0;
      comp_move   <= '0;
      hold_cnt    <= '0;
      p1_bullet   <= '0;
      comp_bullet <= '0;
      p1_shown    <= '0;
      comp_shown  <= '0;
      winner      <= WIN_NONE;
      game_over   <= 1'b0;
      round_done  <= 1'b0;
      move_reject <= 1'b0;
      round_count <= '0;
    end else begin
      round_done  <= 1'b0;
      move_reject <= 1'b0;
      if (new_game) begin
        state       <= ST_WAIT_P1;
        p1_move     <= '0;
        comp_move   <= '0;
        p1_bullet   <= START_CNT;
        comp_bullet <= START_CNT;
        p1_shown    <= '0;
        comp_shown  <= '0;
        winner      <= WIN_NONE;
        game_over   <= 1'b0;
        round_count <= '0;
      end else begin
        case (state)
          ST_WAIT_P1: begin
            if (p1_valid) begin
              if (move_legal(p1_choice, p1_bullet)) begin
                p1_move <= p1_choice;
                state   <= ST_SAMPLE;
              end else begin
                move_reject <= 1'b1;
              end
            end
          end
          // round_done is registered here so it is high during RESOLVE.
          ST_SAMPLE: begin
            comp_move  <= move_legal(comp_choice, comp_bullet) ? comp_choice : MOVE_BLOCK;
            round_done <= 1'b1;
            state      <= ST_RESOLVE;
          end
          ST_RESOLVE: begin
            p1_shown    <= p1_move;
            comp_shown  <= comp_move;
            p1_bullet   <= p1_next;
            comp_bullet <= comp_next;
            winner      <= win_next;
            if (round_count != 8'hff)
              round_count <= round_count + 8'd1;
            hold_cnt    <= HOLD_LOAD;
            state       <= ST_HOLD;
          end
          ST_HOLD: begin
            if (hold_cnt == '0) begin
              if (winner != WIN_NONE) begin
                state     <= ST_GAME_OVER;
                game_over <= 1'b1;
              end else begin
                state <= ST_WAIT_P1;
              end
            end else begin
              hold_cnt <= hold_cnt - 1'b1;
            end
          end
          ST_IDLE, ST_GAME_OVER: ;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_standoff_referee.sv
// Self-checking bench for standoff_referee: scoreboard of expected round results.
module tb_standoff_referee;

  localparam int HOLD = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       new_game;
  logic       p1_valid;
  logic [2:0] p1_choice;
  logic [2:0] comp_choice;
  logic [1:0] p1_bullet;
  logic [1:0] comp_bullet;
  logic [2:0] p1_shown;
  logic [2:0] comp_shown;
  logic [1:0] winner;
  logic       game_over;
  logic       round_done;
  logic       move_reject;
  logic [7:0] round_count;

  standoff_referee #(.HOLD_CYCLES(HOLD), .START_BULLETS(1)) dut (
    .clk         (clk),
    .reset       (reset),
    .new_game    (new_game),
    .p1_valid    (p1_valid),
    .p1_choice   (p1_choice),
    .comp_choice (comp_choice),
    .p1_bullet   (p1_bullet),
    .comp_bullet (comp_bullet),
    .p1_shown    (p1_shown),
    .comp_shown  (comp_shown),
    .winner      (winner),
    .game_over   (game_over),
    .round_done  (round_done),
    .move_reject (move_reject),
    .round_count (round_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] p1b;
    logic [1:0] cb;
    logic [2:0] p1s;
    logic [2:0] cs;
    logic [1:0] win;
    logic [7:0] rc;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   m_p1, m_comp, m_rc;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_new_game();
    m_p1 = 1; m_comp = 1; m_rc = 0;
  endtask

  // Reference outcome table, one row per (player, legalised computer) pair.
  task automatic model_round(input logic [2:0] p, input logic [2:0] c_raw, output exp_t e);
    logic [2:0] c;
    logic [1:0] w;
    logic       c_ok;
    c_ok = (c_raw == 3'b001) || (c_raw == 3'b100 && m_comp > 0) || (c_raw == 3'b010 && m_comp < 3);
    c = c_ok ? c_raw : 3'b001;
    w = 2'b00;
    case ({p, c})
      6'b100_100: begin m_p1--; m_comp--; end
      6'b100_010: begin m_p1--; w = 2'b01; end
      6'b100_001: m_p1--;
      6'b010_100: begin m_comp--; w = 2'b10; end
      6'b010_010: begin m_p1 = (m_p1 == 3) ? 3 : m_p1 + 1; m_comp = (m_comp == 3) ? 3 : m_comp + 1; end
      6'b010_001: m_p1 = (m_p1 == 3) ? 3 : m_p1 + 1;
      6'b001_100: m_comp--;
      6'b001_010: m_comp = (m_comp == 3) ? 3 : m_comp + 1;
      default: ;
    endcase
    m_rc = (m_rc == 255) ? 255 : m_rc + 1;
    e = {2'(m_p1), 2'(m_comp), p, c, w, 8'(m_rc)};
  endtask

  task automatic pulse_new_game();
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    model_new_game();
  endtask

  task automatic play_round(input logic [2:0] p, input logic [2:0] c, input bit wait_hold);
    exp_t e, got;
    int   lat;
    model_round(p, c, e);
    sb_q.push_back(e);
    p1_valid = 1'b1; p1_choice = p; comp_choice = c;
    tick();
    p1_valid = 1'b0;
    lat = 1;
    while (round_done !== 1'b1 && lat < 10) begin
      tick();
      lat++;
    end
    n_cmp++;
    if (lat != 2) begin
      n_bad++;
      $display("FAIL round_done_latency: got %0d cycles, want 2", lat);
    end
    tick();
    got = {p1_bullet, comp_bullet, p1_shown, comp_shown, winner, round_count};
    e = sb_q.pop_front();
    n_cmp++;
    if (got !== e) begin
      n_bad++;
      $display("FAIL round_result p%b c%b: got p1b=%0d cb=%0d p1s=%b cs=%b win=%b rc=%0d, want p1b=%0d cb=%0d p1s=%b cs=%b win=%b rc=%0d",
               p, c, got.p1b, got.cb, got.p1s, got.cs, got.win, got.rc,
               e.p1b, e.cb, e.p1s, e.cs, e.win, e.rc);
    end
    if (wait_hold) begin
      repeat (HOLD - 1) tick();
      n_cmp++;
      if (game_over !== 1'b0) begin
        n_bad++;
        $display("FAIL hold_early_exit: game_over got %b want 0", game_over);
      end
      tick();
      n_cmp++;
      if (game_over !== (e.win != 2'b00)) begin
        n_bad++;
        $display("FAIL hold_exit_game_over: got %b want %b", game_over, (e.win != 2'b00));
      end
    end
  endtask

  task automatic expect_reject(input logic [2:0] p, input string name);
    p1_valid = 1'b1; p1_choice = p;
    tick();
    p1_valid = 1'b0;
    n_cmp++;
    if (move_reject !== 1'b1) begin
      n_bad++;
      $display("FAIL %s reject: move_reject got %b want 1", name, move_reject);
    end
    tick();
    n_cmp++;
    if ({move_reject, round_done} !== 2'b00) begin
      n_bad++;
      $display("FAIL %s after_reject: reject/done got %b want 00", name, {move_reject, round_done});
    end
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({p1_bullet, comp_bullet, p1_shown, comp_shown, winner} !== 12'h000) begin
      n_bad++;
      $display("FAIL reset_values: got %h want 000", {p1_bullet, comp_bullet, p1_shown, comp_shown, winner});
    end
    n_cmp++;
    if ({game_over, round_done, move_reject, round_count} !== 11'h000) begin
      n_bad++;
      $display("FAIL reset_flags: got %h want 000", {game_over, round_done, move_reject, round_count});
    end
  endtask

  task automatic test_new_game();
    pulse_new_game();
    n_cmp++;
    if ({p1_bullet, comp_bullet, winner, round_count, game_over} !== {2'd1, 2'd1, 2'b00, 8'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL new_game_init: got p1b=%0d cb=%0d win=%b rc=%0d go=%b want 1 1 00 0 0",
               p1_bullet, comp_bullet, winner, round_count, game_over);
    end
  endtask

  task automatic test_shoot_vs_reload();
    play_round(3'b100, 3'b010, 1);
    n_cmp++;
    if (winner !== 2'b01) begin
      n_bad++;
      $display("FAIL shoot_reload_winner: got %b want 01", winner);
    end
  endtask

  task automatic test_game_over_frozen();
    p1_valid = 1'b1; p1_choice = 3'b010; comp_choice = 3'b100;
    tick();
    p1_valid = 1'b0;
    n_cmp++;
    if (move_reject !== 1'b0) begin
      n_bad++;
      $display("FAIL game_over_no_reject: got %b want 0", move_reject);
    end
    repeat (3) tick();
    n_cmp++;
    if ({p1_bullet, comp_bullet, winner, game_over, round_done, round_count} !== {2'd0, 2'd1, 2'b01, 1'b1, 1'b0, 8'd1}) begin
      n_bad++;
      $display("FAIL game_over_frozen: got p1b=%0d cb=%0d win=%b go=%b rd=%b rc=%0d want 0 1 01 1 0 1",
               p1_bullet, comp_bullet, winner, game_over, round_done, round_count);
    end
  endtask

  task automatic test_both_shoot_and_reject();
    pulse_new_game();
    play_round(3'b100, 3'b100, 1);
    expect_reject(3'b100, "shoot_empty");
    expect_reject(3'b110, "not_onehot");
    play_round(3'b001, 3'b001, 1);
  endtask

  task automatic test_reload_limits();
    pulse_new_game();
    play_round(3'b010, 3'b001, 1);
    play_round(3'b010, 3'b001, 1);
    expect_reject(3'b010, "reload_full");
    play_round(3'b001, 3'b010, 1);
    play_round(3'b001, 3'b010, 1);
    play_round(3'b001, 3'b010, 1);
    n_cmp++;
    if (comp_shown !== 3'b001) begin
      n_bad++;
      $display("FAIL comp_illegal_shown: got %b want 001", comp_shown);
    end
  endtask

  task automatic test_new_game_in_hold();
    pulse_new_game();
    play_round(3'b010, 3'b001, 0);
    tick();
    pulse_new_game();
    n_cmp++;
    if ({p1_bullet, comp_bullet, p1_shown, comp_shown, winner, round_count} !== {2'd1, 2'd1, 3'b000, 3'b000, 2'b00, 8'd0}) begin
      n_bad++;
      $display("FAIL new_game_in_hold: got p1b=%0d cb=%0d p1s=%b cs=%b win=%b rc=%0d want 1 1 000 000 00 0",
               p1_bullet, comp_bullet, p1_shown, comp_shown, winner, round_count);
    end
    play_round(3'b001, 3'b100, 1);
  endtask

  task automatic test_reset_mid_round();
    int seen_done;
    pulse_new_game();
    p1_valid = 1'b1; p1_choice = 3'b100; comp_choice = 3'b010;
    tick();
    p1_valid = 1'b0;
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({p1_bullet, comp_bullet, p1_shown, comp_shown, winner, game_over, round_done, move_reject, round_count} !== 23'h0) begin
      n_bad++;
      $display("FAIL reset_mid_round: got %h want 0",
               {p1_bullet, comp_bullet, p1_shown, comp_shown, winner, game_over, round_done, move_reject, round_count});
    end
    tick();
    reset = 1'b1;
    seen_done = 0;
    p1_valid = 1'b1; p1_choice = 3'b001;
    for (int i = 0; i < 4; i++) begin
      tick();
      p1_valid = 1'b0;
      if (round_done === 1'b1 || move_reject === 1'b1 || winner !== 2'b00) seen_done++;
    end
    n_cmp++;
    if (seen_done != 0) begin
      n_bad++;
      $display("FAIL reset_idle_quiet: got %0d active cycles want 0", seen_done);
    end
  endtask

  task automatic test_round_count_saturation();
    pulse_new_game();
    for (int i = 0; i < 256; i++) play_round(3'b001, 3'b001, 1);
    n_cmp++;
    if (round_count !== 8'd255) begin
      n_bad++;
      $display("FAIL round_count_sat: got %0d want 255", round_count);
    end
  endtask

  initial begin
    reset = 1'b0; new_game = 1'b0; p1_valid = 1'b0;
    p1_choice = 3'b000; comp_choice = 3'b000;
    model_new_game();
    repeat (3) tick();
    test_reset();
    reset = 1'b1;
    tick();
    test_new_game();
    test_shoot_vs_reload();
    test_game_over_frozen();
    test_both_shoot_and_reject();
    test_reload_limits();
    test_new_game_in_hold();
    test_reset_mid_round();
    test_round_count_saturation();
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d left want 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/standoff_referee.md
# standoff_referee

Round controller and referee for the standoff game. It accepts the human player's one-hot move and samples the computer opponent's one-hot move. It applies the shoot/reload/block rules, keeps both bullet counters and declares the winner. Its `p1_bullet` and `comp_bullet` outputs drive the computer opponent's bullet inputs directly, closing the decision loop. Its revealed moves and winner feed the display logic.

## Interface
Parameters:
- `HOLD_CYCLES`, default 50_000_000: cycles the reveal is held after each round before the next move is accepted. Must be ≥ 2.
- `START_BULLETS`, default 1: bullet count loaded for both players on `new_game`. Range 0..3.

Ports:
- `clk` input 1: single system clock; all state on its rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `new_game` input 1: synchronous one-cycle pulse that starts or restarts a game.
- `p1_valid` input 1: one-cycle pulse; `p1_choice` is valid.
- `p1_choice` input 3: one-hot move: 100 shoot, 010 reload, 001 block.
- `comp_choice` input 3: computer move, same encoding.
- `p1_bullet` output 2: player bullet count.
- `comp_bullet` output 2: computer bullet count.
- `p1_shown` output 3: registered player move of the last round.
- `comp_shown` output 3: registered computer move of the last round.
- `winner` output 2: 00 none, 01 player, 10 computer.
- `game_over` output 1: high while in GAME_OVER.
- `round_done` output 1: one-cycle pulse when a round resolves.
- `move_reject` output 1: one-cycle pulse when an illegal player move is refused.
- `round_count` output 8: rounds resolved this game, saturating at 255.

## Operation
- Reset values:
  - State: IDLE.
  - All outputs 0; `winner`=00.
- States: IDLE, WAIT_P1, SAMPLE, RESOLVE, HOLD, GAME_OVER.
- IDLE → WAIT_P1 on `new_game`. On entry:
  - Both bullet counts = START_BULLETS.
  - `round_count`, `winner`, `p1_shown`, `comp_shown` cleared.
- `new_game` in any non-IDLE state performs the same reinitialisation and goes to WAIT_P1. It has priority over every other event in that cycle.
- WAIT_P1, on `p1_valid`:
  - Illegal move: not one-hot, shoot with `p1_bullet`=0, or reload with `p1_bullet`=3. Pulse `move_reject` and stay in WAIT_P1.
  - Legal move: latch it and go to SAMPLE.
- `p1_valid` outside WAIT_P1 is ignored, with no reject pulse.
- SAMPLE: register `comp_choice`. An illegal computer move (not one-hot, or an impossible shoot/reload) is recorded as block (001). Go to RESOLVE.
- RESOLVE: apply rules using registered moves and pre-round counts. Update `p1_shown`, `comp_shown`, counts, `winner` and `round_count`, pulse `round_done`, and go to HOLD.
  - Shoot vs reload: shooter wins and shooter's count −1. Reloader's count is not incremented.
  - Shoot vs shoot: both −1, no winner.
  - Shoot vs block: shooter −1, no winner.
  - Reload: +1, saturating at 3.
  - Block: no change.
- HOLD: count HOLD_CYCLES cycles, then go to GAME_OVER if `winner`≠00, else to WAIT_P1.
- GAME_OVER: all outputs frozen until `new_game`.

## Timing
- Accept cycle (`p1_valid` high in WAIT_P1) = cycle N:
  - SAMPLE at N+1.
  - RESOLVE at N+2; `round_done` high during N+2.
  - Updated outputs visible at N+3.
- Earliest next accept is N+3+HOLD_CYCLES.
- Bullet outputs are stable for ≥ HOLD_CYCLES ≥ 2 cycles before the next SAMPLE. This covers the computer opponent's one-cycle registered eligibility path.
- `move_reject` is asserted the cycle after the rejected `p1_valid`.
- Bullet arithmetic is 2-bit, saturating at both ends. A decrement at 0 cannot occur, because moves are legalised first.
- Reset asserted mid-round aborts immediately to IDLE. No partial update survives.

## Structure
- Shared package `standoff_pkg` holds:
  - Move encodings `MOVE_SHOOT`, `MOVE_RELOAD`, `MOVE_BLOCK`.
  - Winner codes `WIN_NONE`, `WIN_P1`, `WIN_COMP`.
  - `MAX_BULLETS`=3.
  - The state enum.
- One sub-module, `standoff_rules`: combinational rule evaluation. Inputs are both moves and both counts; outputs are the next counts and the winner. It is shared with any future two-player mode.

## Test plan
- Reset, then `new_game` with START_BULLETS=1 → counts 1/1, WAIT_P1, `winner`=00, `round_count`=0.
- Player shoot, computer reload, counts 1/1 → `round_done` at N+2; then `winner`=01, `p1_bullet`=0, `comp_bullet`=1, GAME_OVER after HOLD.
- Both shoot at 1/1 → counts 0/0, `winner`=00, back to WAIT_P1; a following player shoot → `move_reject` pulse and state unchanged.
- Player reload at `p1_bullet`=3 → reject. Player block vs computer reload at `comp_bullet`=3 (illegal) → computer treated as block, counts unchanged, `comp_shown`=001.
- `new_game` pulsed during HOLD → counts back to START_BULLETS and WAIT_P1 next cycle. `reset` pulsed during SAMPLE → IDLE with all outputs 0.
- 256 block/block rounds → `round_count` saturates at 255.
